// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard controller
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int OVF_BIT   = 8;
    localparam int FERR_BIT  = 9;
    localparam int VALID_BIT = 15;
    localparam int EXT_BIT   = 8;

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 line synchroniser and 11-bit frame receiver
// Runs entirely on i_clk; PS/2 clock is only sampled, never used as a clock.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err_pulse
);

    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    // [1:0] synchroniser stages, [2] previous synchronised value for edge detect
    logic [2:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    frame_state_t  r_state;
    frame_state_t  w_state_next;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_timer;
    logic          w_fall;
    logic          w_bit;
    logic          w_timeout;
    logic          w_frame_ok;

    assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit      = r_dat_sync[1];
    assign w_timeout  = (r_state != IDLE) && !w_fall && (r_timer == TIMER_LAST);
    assign w_frame_ok = w_bit && (r_parity == ~^r_shift);
    assign o_byte     = r_shift;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        o_byte_valid      = 1'b0;
        o_frame_err_pulse = 1'b0;
        if (w_timeout) begin
            w_state_next      = IDLE;
            o_frame_err_pulse = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE:   if (!w_bit) w_state_next = DATA;
                DATA:   if (r_bit_cnt == 3'd7) w_state_next = PARITY;
                PARITY: w_state_next = STOP;
                STOP: begin
                    w_state_next = IDLE;
                    if (w_frame_ok) o_byte_valid      = 1'b1;
                    else            o_frame_err_pulse = 1'b1;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_timer   <= '0;
        end else begin
            if (w_fall || r_state == IDLE) r_timer <= '0;
            else                           r_timer <= r_timer + 1'b1;
            if (w_fall) begin
                case (r_state)
                    IDLE:   r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    PARITY: r_parity <= w_bit;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_controller.sv
// rtl/ps2_keyboard_controller.sv - PS/2 keyboard scan-code decoder, FIFO and CPU bus window
module ps2_keyboard_controller
    import ps2_pkg::*;
#(
    parameter logic [13:0] DATA_ADDRESS   = 14'h2500,
    parameter logic [13:0] STATUS_ADDRESS = 14'h2501,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic [13:0] address,
    input  logic        read,
    input  logic        PS2_clk,
    input  logic        PS2_data,
    output logic [63:0] data,
    output logic        key_ready
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    w_byte;
    logic          w_byte_valid;
    logic          w_frame_err_pulse;
    logic          r_ext;
    logic          r_brk;
    logic          r_ovf;
    logic          r_ferr;
    logic          r_read_d;
    logic          r_key_ready;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_hold;
    logic [15:0]   w_head_word;
    logic [63:0]   w_word;
    logic          w_push;
    logic          w_wr;
    logic          w_pop;
    logic          w_ovf_set;
    logic          w_data_sel;
    logic          w_stat_sel;
    logic          w_first;
    logic          w_full;
    logic          w_empty;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk             (system_clk),
        .i_reset           (reset),
        .i_ps2_clk         (PS2_clk),
        .i_ps2_data        (PS2_data),
        .o_byte            (w_byte),
        .o_byte_valid      (w_byte_valid),
        .o_frame_err_pulse (w_frame_err_pulse)
    );

    assign w_push     = w_byte_valid && (w_byte != PS2_EXT) && (w_byte != PS2_BRK) && !r_brk;
    assign w_data_sel = read && (address == DATA_ADDRESS);
    assign w_stat_sel = read && (address == STATUS_ADDRESS);
    assign w_first    = read && !r_read_d;
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = w_first && w_data_sel && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_ovf_set  = w_push && w_full && !w_pop;
    assign key_ready  = r_key_ready;

    always_comb begin
        w_head_word = '0;
        if (!w_empty) begin
            w_head_word[VALID_BIT]   = 1'b1;
            w_head_word[EXT_BIT:0]   = r_mem[r_rd_ptr];
        end
    end

    always_comb begin
        w_word = '0;
        if (w_data_sel) begin
            w_word[15:0] = w_first ? w_head_word : r_hold;
        end else if (w_stat_sel) begin
            w_word[AW:0]     = r_count;
            w_word[OVF_BIT]  = r_ovf;
            w_word[FERR_BIT] = r_ferr;
        end
    end

    assign data = (w_data_sel || w_stat_sel) ? w_word : 64'bz;

    always_ff @(posedge system_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_ext, w_byte};
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_ovf       <= 1'b0;
            r_ferr      <= 1'b0;
            r_read_d    <= 1'b0;
            r_key_ready <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_hold      <= '0;
        end else begin
            r_read_d    <= read;
            r_key_ready <= !w_empty;
            if (w_byte_valid) begin
                if (w_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_first && w_data_sel) r_hold <= w_head_word;
            if (w_ovf_set)                   r_ovf <= 1'b1;
            else if (w_first && w_stat_sel)  r_ovf <= 1'b0;
            if (w_frame_err_pulse)           r_ferr <= 1'b1;
            else if (w_first && w_stat_sel)  r_ferr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_controller.sv
// tb/tb_ps2_keyboard_controller.sv - randomized self-checking bench with a scan-code queue model
module tb_ps2_keyboard_controller;

    localparam logic [13:0] DADDR = 14'h2500;
    localparam logic [13:0] SADDR = 14'h2501;
    localparam int          DEPTH = 8;
    localparam int          TOUT  = 400;

    logic        system_clk = 1'b0;
    logic        reset      = 1'b1;
    logic [13:0] address    = '0;
    logic        read       = 1'b0;
    logic        PS2_clk    = 1'b1;
    logic        PS2_data   = 1'b1;
    wire  [63:0] data;
    logic        key_ready;

    ps2_keyboard_controller #(
        .DATA_ADDRESS   (DADDR),
        .STATUS_ADDRESS (SADDR),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .PS2_clk    (PS2_clk),
        .PS2_data   (PS2_data),
        .data       (data),
        .key_ready  (key_ready)
    );

    always #5 system_clk = ~system_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] m_q[$];
    bit         m_ext, m_brk, m_ovf, m_ferr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ferr = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (!m_brk) begin
                if (m_q.size() == DEPTH) m_ovf = 1;
                else m_q.push_back({m_ext, b});
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic b, input int h);
        @(negedge system_clk);
        PS2_data = b;
        repeat (h) @(negedge system_clk);
        PS2_clk = 1'b0;
        repeat (h) @(negedge system_clk);
        PS2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int h;
        h = $urandom_range(3, 8);
        ps2_bit(1'b0, h);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], h);
        ps2_bit((~^b) ^ bad_par, h);
        ps2_bit(~bad_stop, h);
        PS2_data = 1'b1;
        repeat (8) @(negedge system_clk);
        model_byte(b, !(bad_par || bad_stop));
    endtask

    task automatic bus_read(input logic [13:0] a, input int n,
                            output logic [63:0] w0, output logic [63:0] wl);
        @(negedge system_clk);
        address = a;
        read    = 1'b1;
        #1 w0 = data;
        for (int i = 1; i < n; i++) begin
            @(negedge system_clk);
            #1;
        end
        wl = data;
        @(negedge system_clk);
        read = 1'b0;
        @(negedge system_clk);
    endtask

    task automatic read_data_chk(input string tag, input int n);
        logic [63:0] w0, wl, exp;
        logic [8:0]  e;
        exp = 64'h0;
        if (m_q.size() != 0) begin
            e   = m_q.pop_front();
            exp = 64'h8000 + 64'(e);
        end
        bus_read(DADDR, n, w0, wl);
        check({tag, "_data"}, w0, exp);
        if (n > 1) check({tag, "_hold"}, wl, exp);
        check({tag, "_kr"}, {63'b0, key_ready}, {63'b0, m_q.size() != 0});
    endtask

    task automatic read_stat_chk(input string tag);
        logic [63:0] w0, wl, exp;
        exp = 64'(m_q.size()) + (64'(m_ovf) << 8) + (64'(m_ferr) << 9);
        bus_read(SADDR, 1, w0, wl);
        check({tag, "_stat"}, w0, exp);
        m_ovf  = 0;
        m_ferr = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] codes [9];
        logic [7:0] b;
        int         k;
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        model_reset();
        repeat (4) @(negedge system_clk);
        reset = 1'b0;
        @(negedge system_clk);
        check("reset_kr", {63'b0, key_ready}, 64'h0);
        read_stat_chk("reset");

        send_frame(8'h1C, 0, 0);
        check("make_kr", {63'b0, key_ready}, 64'h1);
        read_data_chk("make1c", 1);
        read_stat_chk("after_make");

        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        read_stat_chk("break");
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        read_data_chk("ext75", 1);

        send_frame(8'h1C, 1, 0);
        read_stat_chk("parity1");
        read_stat_chk("parity2");

        for (int i = 0; i < 9; i++) send_frame(codes[i], 0, 0);
        read_stat_chk("overflow");
        for (int i = 0; i < 9; i++) read_data_chk($sformatf("drain%0d", i), 1);

        ps2_bit(1'b0, 4);
        ps2_bit(1'b1, 4);
        ps2_bit(1'b0, 4);
        ps2_bit(1'b1, 4);
        repeat (TOUT + 50) @(negedge system_clk);
        m_ferr = 1;
        read_stat_chk("timeout");
        send_frame(8'h29, 0, 0);
        read_data_chk("post_to", 1);

        send_frame(8'h1C, 0, 0);
        send_frame(8'h32, 0, 0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0], 4);
        PS2_data = 1'b1;
        @(negedge system_clk);
        reset = 1'b1;
        @(negedge system_clk);
        reset = 1'b0;
        model_reset();
        #1 check("rst_mid_kr", {63'b0, key_ready}, 64'h0);
        read_stat_chk("rst_mid");
        send_frame(8'h1E, 0, 0);
        read_data_chk("held3", 3);
        read_stat_chk("held3_after");

        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 0) send_frame(b, 1, 0);
                else send_frame(b, 0, 1);
            end else if (k == 1) begin
                send_frame(8'hE0, 0, 0);
            end else if (k == 2) begin
                send_frame(8'hF0, 0, 0);
            end else begin
                do b = 8'($urandom_range(1, 255)); while (b == 8'hE0 || b == 8'hF0);
                send_frame(b, 0, 0);
            end
            k = $urandom_range(0, 5);
            if (k < 2) read_data_chk($sformatf("rnd%0d", it), $urandom_range(1, 3));
            else if (k == 2) read_stat_chk($sformatf("rnd%0d", it));
        end
        for (int i = 0; i < DEPTH + 1; i++) read_data_chk($sformatf("final%0d", i), 1);
        read_stat_chk("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_controller.md
Name: ps2_keyboard_controller

Overview:
Receives PS/2 keyboard frames, assembles scan-code sequences and buffers make codes for CPU polling.
- PS2_clk and PS2_data are sampled in the system_clk domain; no logic is clocked by PS2_clk.
- E0 (extended) and F0 (break) prefixes are decoded; break sequences are discarded.
- Accepted codes go into a FIFO that the CPU reads through two memory-mapped words on the shared 64-bit tri-state data bus.

Parameters:
DATA_ADDRESS, 14'h2500, address of the pop-on-read scan-code word
STATUS_ADDRESS, 14'h2501, address of the status word (clears sticky flags on read)
FIFO_DEPTH, 8, scan-code FIFO entries; power of two, at least 2
TIMEOUT_CYCLES, 50000, system_clk cycles without a PS2 falling edge before a partial frame is abandoned

Ports:
system_clk  input  1  the only clock
reset  input  1  synchronous, active-high
address  input  14  CPU word address
read  input  1  CPU read strobe, held for the whole access
PS2_clk  input  1  raw PS/2 clock, asynchronous
PS2_data  input  1  raw PS/2 data, asynchronous
data  output  64  read data; 64'bz unless read is high and address matches
key_ready  output  1  FIFO non-empty; reset value 0

Behaviour:
- Interface: one clock, system_clk; reset is synchronous and active-high.
- Reset (sampled on a system_clk edge):
  - frame FSM to IDLE; FIFO flushed (count 0); prefix and sticky flags cleared; timeout counter 0.
  - key_ready = 0; data = z.
  - A partial frame in flight at reset is lost. Bits arriving after reset start a fresh frame at the next start bit.
- Synchronisation:
  - 2-flop synchronisers on both PS2 lines.
  - Falling edge = synchronised clock was 1 last cycle and is 0 now.
  - Data is sampled on the falling-edge cycle.
- Frame FSM, advancing only on falling edges:
  - IDLE: data 0 -> DATA with bit count 0; data 1 -> stay IDLE (spurious edge ignored).
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: the byte is good when stop = 1 and parity = ~^byte (odd parity over data+parity). Good: byte_valid pulses 1 cycle. Bad: frame_err sticky set, byte dropped. Both cases -> IDLE.
  - Timeout: counter resets on every falling edge and counts in any non-IDLE state. Reaching TIMEOUT_CYCLES -> IDLE and frame_err set.
- Decoder, acting on byte_valid:
  - 8'hE0: set ext.
  - 8'hF0: set brk.
  - Any other byte: if brk, discard it; otherwise push {ext, byte}. Then clear ext and brk.
- FIFO entry is 9 bits: {ext, code}.
  - Push when full: entry dropped, overflow sticky set.
  - Push and pop in the same cycle when full: both happen; count unchanged; no overflow.
  - Pop when empty: no effect.
- Read access:
  - Read cycle 1 (read high, previous-cycle read low, address match) is the only cycle that pops or clears.
  - DATA_ADDRESS word: bits[7:0] code, bit 8 ext, bit 15 valid, all other bits 0.
    - Cycle 1: the FIFO head is driven combinationally, captured into a hold register and popped if non-empty.
    - Later cycles of the same read drive the hold register.
    - Empty FIFO: word = 64'h0 and no pop.
  - STATUS_ADDRESS word: bits[$clog2(FIFO_DEPTH):0] count, bit 8 overflow, bit 9 frame_err, all other bits 0.
    - Both sticky bits clear at the end of cycle 1.
    - A sticky event in that same cycle stays set (set wins over clear).
- key_ready = (count != 0), registered from count.

Decomposition:
- Package ps2_pkg holds:
  - frame-state enum (IDLE, DATA, PARITY, STOP);
  - prefix constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0;
  - status bit positions (OVF_BIT = 8, FERR_BIT = 9, VALID_BIT = 15, EXT_BIT = 8).
- Sub-module ps2_rx_frame contains synchronisers, edge detect, frame FSM, parity check and timeout. It outputs byte, byte_valid and frame_err_pulse.
- Decoder, FIFO and bus logic stay in the top module.

Test Plan:
- Frame 0x1C, parity 0, stop 1, then read DATA_ADDRESS -> key_ready rises; data = 64'h0000_0000_0000_801C; a following status read shows count 0 and key_ready = 0.
- Bytes F0, 1C -> no push; count stays 0. Then bytes E0, 75 -> read returns 64'h...8175.
- 0x1C sent with parity 1 -> no push; status read returns bit 9 set; a second status read returns bit 9 clear.
- Nine make codes 0x16..0x46 with no reads -> count 8 and overflow set. Eight DATA reads return the first eight codes in order; a ninth read returns 64'h0.
- Four bits of a frame, then PS2_clk idle for TIMEOUT_CYCLES -> frame_err set. A following clean 0x29 frame reads back as 64'h...8029.
- reset asserted mid-frame with two codes queued -> count 0 and key_ready 0 on the next cycle. The next full 0x1E frame is received correctly; a read held 3 cycles pops exactly once.
